// File: rtl/nand_sweep_ctrl.sv
// Self-test sequencer: steps a 4-input gate through all 16 vectors, samples X, checks vs EXPECTED.
// Latency: done pulses 16*(SETTLE_CYCLES+1)+1 cycles after the accepting start edge.
// Backpressure: none; start is accepted only in IDLE, otherwise dropped (no queuing).
// Optional build macro SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module nand_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        x_i,
    output logic        a_o,
    output logic        b_o,
    output logic        c_o,
    output logic        d_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] table_o,
    output logic [4:0]  err_count_o,
    output logic        pass_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Terminal settle count; unused when SETTLE_CYCLES is 0 because SETTLE is skipped.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam bit         NO_SETTLE   = (SETTLE_CYCLES == 0);

    state_t      state_q;
    logic [3:0]  vec_q;      // current vector index, driven directly onto A..D
    logic [7:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] table_q;
    logic [4:0]  err_q;
    logic        pass_q;

    logic        mismatch;
    logic        stop_early;
    logic [15:0] table_d;
    logic [4:0]  err_d;

    // Sample-time updates of the result registers, applied on the SAMPLE exit edge.
    always_comb begin
        mismatch = (x_i != EXPECTED[vec_q]);
        table_d  = table_q | (16'(x_i) << vec_q);
        err_d    = err_q + {4'd0, mismatch};
`ifdef SWEEP_STOP_ON_ERR_EN
        stop_early = mismatch;
`else
        stop_early = 1'b0;
`endif
    end

    // Sweep FSM with all outputs registered; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= 16'h0000;
            err_q   <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        vec_q   <= 4'd0;
                        cnt_q   <= 8'd0;
                        table_q <= 16'h0000;
                        err_q   <= 5'd0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= 8'd0;
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    table_q <= table_d;
                    err_q   <= err_d;
                    if (vec_q == 4'd15 || stop_early) begin
                        // Vector stays on A..D; pass reflects the final count.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 5'd0);
                        state_q <= ST_DONE;
                    end else begin
                        vec_q   <= vec_q + 4'd1;
                        cnt_q   <= 8'd0;
                        state_q <= NO_SETTLE ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_o         = vec_q[3];
    assign b_o         = vec_q[2];
    assign c_o         = vec_q[1];
    assign d_o         = vec_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign table_o     = table_q;
    assign err_count_o = err_q;
    assign pass_o      = pass_q;

endmodule

// File: tb/tb_nand_sweep_ctrl.sv
// Directed bench for nand_sweep_ctrl with default parameters (settle = 2, expected = NAND4).
// The gate under test is modelled in the bench: NAND4, AND4, or NAND4 with index 5 stuck at 0.
// Expectations follow the build macro SWEEP_STOP_ON_ERR_EN for the stuck-fault scenario.
module tb_nand_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        x;
    logic        a, b, c, d;
    logic        busy, done;
    logic [15:0] tbl;
    logic [4:0]  errc;
    logic        pass;
    logic [3:0]  vec;
    int          mode = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    nand_sweep_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .x_i         (x),
        .a_o         (a),
        .b_o         (b),
        .c_o         (c),
        .d_o         (d),
        .busy_o      (busy),
        .done_o      (done),
        .table_o     (tbl),
        .err_count_o (errc),
        .pass_o      (pass)
    );

    always #5 clk = ~clk;

    assign vec = {a, b, c, d};

    // Gate model under test.
    always_comb begin
        case (mode)
            1:       x = a & b & c & d;
            2:       x = (vec == 4'd5) ? 1'b0 : ~(a & b & c & d);
            default: x = ~(a & b & c & d);
        endcase
    end

    // Starts a sweep and observes it cycle by cycle (cycle 1 = first cycle after the
    // accepting edge). Returns the done cycle (-1 if never seen), busy cycle count and
    // number of busy cycles whose vector differed from (k-1)/3.
    task automatic run_sweep(input bit hold, input int repulse_at,
                             output int done_cyc, output int busy_cnt, output int vec_bad);
        done_cyc = -1;
        busy_cnt = 0;
        vec_bad  = 0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
                if (!hold) start = 1'b0;
            end
            if (k == repulse_at) start = 1'b1;
            if (busy) begin
                busy_cnt++;
                if (vec != 4'((k - 1) / 3)) vec_bad++;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({vec, busy, done, tbl, errc, pass} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_values: got vec=%h busy=%b done=%b table=%h err=%0d pass=%b, want all 0",
                     vec, busy, done, tbl, errc, pass);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_nand_default();
        int dc, bc, vb;
        mode = 0;
        run_sweep(1'b0, 0, dc, bc, vb);
        n_checks++;
        if (dc !== 49) begin n_fail++; $display("FAIL nand_done_cycle: got %0d want 49", dc); end
        n_checks++;
        if (bc !== 48) begin n_fail++; $display("FAIL nand_busy_cycles: got %0d want 48", bc); end
        n_checks++;
        if (vb !== 0) begin n_fail++; $display("FAIL vector_order: %0d busy cycles off sequence, want 0", vb); end
        n_checks++;
        if ({tbl, errc, pass} !== {16'h7FFF, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL nand_result: got table=%h err=%0d pass=%b want 7fff 0 1", tbl, errc, pass);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({done, busy, vec} !== {1'b0, 1'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL done_pulse_hold: got done=%b busy=%b vec=%h want 0 0 f", done, busy, vec);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({vec, tbl, pass} !== {4'hF, 16'h7FFF, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_hold: got vec=%h table=%h pass=%b want f 7fff 1", vec, tbl, pass);
        end
    endtask

    task automatic test_and4();
        int dc, bc, vb;
        mode = 1;
        run_sweep(1'b0, 0, dc, bc, vb);
        n_checks++;
        if (dc !== 49) begin n_fail++; $display("FAIL and4_done_cycle: got %0d want 49", dc); end
        n_checks++;
        if ({tbl, errc, pass} !== {16'h8000, 5'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL and4_result: got table=%h err=%0d pass=%b want 8000 16 0", tbl, errc, pass);
        end
    endtask

    task automatic test_stuck_idx5();
        int dc, bc, vb;
        int          exp_dc;
        logic [15:0] exp_tbl;
        logic [3:0]  exp_vec;
`ifdef SWEEP_STOP_ON_ERR_EN
        exp_dc  = 19;
        exp_tbl = 16'h001F;
        exp_vec = 4'd5;
`else
        exp_dc  = 49;
        exp_tbl = 16'h7FDF;
        exp_vec = 4'hF;
`endif
        mode = 2;
        run_sweep(1'b0, 0, dc, bc, vb);
        n_checks++;
        if (dc !== exp_dc) begin n_fail++; $display("FAIL stuck_done_cycle: got %0d want %0d", dc, exp_dc); end
        n_checks++;
        if ({tbl, errc, pass, vec} !== {exp_tbl, 5'd1, 1'b0, exp_vec}) begin
            n_fail++;
            $display("FAIL stuck_result: got table=%h err=%0d pass=%b vec=%h want %h 1 0 %h",
                     tbl, errc, pass, vec, exp_tbl, exp_vec);
        end
        mode = 0;
    endtask

    task automatic test_repulse();
        int dc, bc, vb;
        mode = 0;
        run_sweep(1'b0, 20, dc, bc, vb);
        n_checks++;
        if ({dc, bc, vb} !== {32'sd49, 32'sd48, 32'sd0}) begin
            n_fail++;
            $display("FAIL repulse_timing: got done=%0d busy=%0d vecbad=%0d want 49 48 0", dc, bc, vb);
        end
        n_checks++;
        if ({tbl, errc, pass} !== {16'h7FFF, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL repulse_result: got table=%h err=%0d pass=%b want 7fff 0 1", tbl, errc, pass);
        end
    endtask

    task automatic test_back_to_back();
        int dc, bc, vb;
        int dc2;
        mode = 0;
        run_sweep(1'b1, 0, dc, bc, vb);
        n_checks++;
        if (dc !== 49) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 49", dc); end
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, tbl, pass} !== {1'b0, 1'b0, 16'h7FFF, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_idle_cycle: got busy=%b done=%b table=%h pass=%b want 0 0 7fff 1",
                     busy, done, tbl, pass);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if ({busy, tbl, errc, pass, vec} !== {1'b1, 16'h0000, 5'd0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy=%b table=%h err=%0d pass=%b vec=%h want 1 0 0 0 0",
                     busy, tbl, errc, pass, vec);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({tbl, vec} !== {16'h0001, 4'd1}) begin
            n_fail++;
            $display("FAIL b2b_partial_table: got table=%h vec=%h want 0001 1", tbl, vec);
        end
        dc2 = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dc2 = k;
                break;
            end
        end
        // 45 more cycles after the partial-table check reaches done cycle 49 of the second sweep.
        n_checks++;
        if ({dc2, tbl, pass} !== {32'sd45, 16'h7FFF, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second_sweep: got done_after=%0d table=%h pass=%b want 45 7fff 1", dc2, tbl, pass);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int dc, bc, vb;
        mode = 0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, vec, tbl} !== {1'b1, 4'd7, 16'h007F}) begin
            n_fail++;
            $display("FAIL mid_sweep_position: got busy=%b vec=%h table=%h want 1 7 007f", busy, vec, tbl);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vec, busy, done, tbl, errc, pass} !== 28'd0) begin
            n_fail++;
            $display("FAIL mid_sweep_reset: got vec=%h busy=%b done=%b table=%h err=%0d pass=%b want all 0",
                     vec, busy, done, tbl, errc, pass);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1'b0, 0, dc, bc, vb);
        n_checks++;
        if ({dc, tbl, errc, pass} !== {32'sd49, 16'h7FFF, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_sweep: got done=%0d table=%h err=%0d pass=%b want 49 7fff 0 1",
                     dc, tbl, errc, pass);
        end
    endtask

    initial begin
        test_reset();
        test_nand_default();
        test_and4();
        test_stuck_idx5();
        test_repulse();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
